// File: rtl/button_press_classifier_if.sv
// Classifier bus: debounced button level in, gesture pulses and status levels out.
interface button_press_classifier_if;
  logic i_btn_level;
  logic o_short;
  logic o_long;
  logic o_double;
  logic o_held;
  logic o_busy;

  // Upstream side: drives the level and consumes the gesture outputs.
  modport master (
    output i_btn_level,
    input  o_short, o_long, o_double, o_held, o_busy
  );

  // Classifier side.
  modport slave (
    input  i_btn_level,
    output o_short, o_long, o_double, o_held, o_busy
  );
endinterface

// File: rtl/button_press_classifier.sv
// Button gesture classifier: turns a debounced button level into one-cycle
// short / long / double-click pulses plus held and busy levels.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no gesture in progress
// PRESS1    | first press, timing toward a long press
// GAP       | released after first press, waiting for a second press
// PRESS2    | second press of a double click, untimed
// LONG_HELD | long press qualified, waiting for release
module button_press_classifier #(
  parameter int LONG_CYCLES = 100_000_000,
  parameter int GAP_CYCLES  = 30_000_000,
  parameter int CNT_W       = 27
) (
  input logic                     i_clk,
  input logic                     i_rst,
  button_press_classifier_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    GAP       = 3'd2,
    PRESS2    = 3'd3,
    LONG_HELD = 3'd4
  } state_t;

  // The counter value seen on the last qualifying sample: the entry sample
  // is not counted, so N samples in a state end with the counter at N-2.
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 2);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 2);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] count;
  logic             short_nxt;
  logic             long_nxt;
  logic             double_nxt;

  // State register and duration counter. Only PRESS1 and GAP are timed and
  // both leave at their limit; the other states hold the counter at zero so
  // it can never wrap however long the button stays in them.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        count <= '0;
      end else if (state == PRESS1 || state == GAP) begin
        count <= count + CNT_W'(1);
      end else begin
        count <= '0;
      end
    end
  end

  // Next-state decode. In GAP a rise is tested first so that a press landing
  // on the expiry sample still counts as the second click.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.i_btn_level) state_nxt = PRESS1;
      end
      PRESS1: begin
        if (!bus.i_btn_level)       state_nxt = GAP;
        else if (count == LONG_LAST) state_nxt = LONG_HELD;
      end
      GAP: begin
        if (bus.i_btn_level)        state_nxt = PRESS2;
        else if (count == GAP_LAST) state_nxt = IDLE;
      end
      PRESS2: begin
        if (!bus.i_btn_level) state_nxt = IDLE;
      end
      LONG_HELD: begin
        if (!bus.i_btn_level) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pulse decode from the transition being taken this cycle; mutually
  // exclusive because each is tied to a different source state.
  always_comb begin
    short_nxt  = (state == GAP) && (state_nxt == IDLE);
    long_nxt   = (state == PRESS1) && (state_nxt == LONG_HELD);
    double_nxt = (state == PRESS2) && (state_nxt == IDLE);
  end

  // Output registers, so nothing combinational reaches the ports.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bus.o_short  <= 1'b0;
      bus.o_long   <= 1'b0;
      bus.o_double <= 1'b0;
      bus.o_held   <= 1'b0;
      bus.o_busy   <= 1'b0;
    end else begin
      bus.o_short  <= short_nxt;
      bus.o_long   <= long_nxt;
      bus.o_double <= double_nxt;
      bus.o_held   <= (state_nxt == LONG_HELD);
      bus.o_busy   <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_button_press_classifier.sv
// Directed bench for button_press_classifier with LONG_CYCLES=8, GAP_CYCLES=5.
// Outputs are logged into per-scenario bitmaps indexed by sample number
// (bit k = output observed just after the k-th sampled level) and compared
// against hand-computed masks.
module tb_button_press_classifier;

  logic clk = 1'b0;
  logic rst = 1'b1;

  button_press_classifier_if bif ();

  button_press_classifier #(
    .LONG_CYCLES(8),
    .GAP_CYCLES (5),
    .CNT_W      (4)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [63:0] m_short, m_long, m_double, m_held, m_busy;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic clear_log();
    cyc      = 0;
    m_short  = '0;
    m_long   = '0;
    m_double = '0;
    m_held   = '0;
    m_busy   = '0;
  endtask

  // Present lvl for n samples, logging outputs 1 time unit after each edge.
  task automatic drive(input logic lvl, input int n);
    for (int i = 0; i < n; i++) begin
      bif.i_btn_level = lvl;
      @(posedge clk);
      #1;
      cyc++;
      if (cyc < 64) begin
        m_short[cyc]  = bif.o_short;
        m_long[cyc]   = bif.o_long;
        m_double[cyc] = bif.o_double;
        m_held[cyc]   = bif.o_held;
        m_busy[cyc]   = bif.o_busy;
      end
    end
  endtask

  initial begin
    bif.i_btn_level = 1'b0;
    #2;
    check("rst_short",  {63'd0, bif.o_short},  64'd0);
    check("rst_long",   {63'd0, bif.o_long},   64'd0);
    check("rst_double", {63'd0, bif.o_double}, 64'd0);
    check("rst_held",   {63'd0, bif.o_held},   64'd0);
    check("rst_busy",   {63'd0, bif.o_busy},   64'd0);
    #20 rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: short press
    clear_log();
    drive(1'b1, 3);
    drive(1'b0, 10);
    check("s1_short",  m_short,  64'h100);
    check("s1_long",   m_long,   64'h0);
    check("s1_double", m_double, 64'h0);
    check("s1_held",   m_held,   64'h0);
    check("s1_busy",   m_busy,   64'h0FE);

    // 2: long press
    clear_log();
    drive(1'b1, 12);
    drive(1'b0, 8);
    check("s2_long",  m_long,  64'h100);
    check("s2_held",  m_held,  64'h1F00);
    check("s2_short", m_short, 64'h0);
    check("s2_busy",  m_busy,  64'h1FFE);

    // 3: double click with a long second press
    clear_log();
    drive(1'b1, 3);
    drive(1'b0, 2);
    drive(1'b1, 20);
    drive(1'b0, 6);
    check("s3_double", m_double, 64'h400_0000);
    check("s3_short",  m_short,  64'h0);
    check("s3_long",   m_long,   64'h0);
    check("s3_held",   m_held,   64'h0);

    // 4a: 4 low samples is inside the gap
    clear_log();
    drive(1'b1, 3);
    drive(1'b0, 4);
    drive(1'b1, 2);
    drive(1'b0, 8);
    check("s4a_double", m_double, 64'h400);
    check("s4a_short",  m_short,  64'h0);

    // 4b: 5 low samples expires the gap; second press is its own short press
    clear_log();
    drive(1'b1, 3);
    drive(1'b0, 5);
    drive(1'b1, 2);
    drive(1'b0, 8);
    check("s4b_short",  m_short,  64'h8100);
    check("s4b_double", m_double, 64'h0);

    // 5: asynchronous reset mid-gesture
    clear_log();
    drive(1'b1, 3);
    drive(1'b0, 2);
    check("s5_busy_pre", {63'd0, bif.o_busy}, 64'd1);
    #2 rst = 1'b1;
    #1;
    check("s5_busy_rst", {63'd0, bif.o_busy}, 64'd0);
    check("s5_outs_rst",
          {59'd0, bif.o_short, bif.o_long, bif.o_double, bif.o_held, bif.o_busy}, 64'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    clear_log();
    drive(1'b0, 10);
    check("s5_pulses", m_short | m_long | m_double, 64'h0);
    check("s5_busy",   m_busy, 64'h0);

    // 6: long press, 1-sample release, then a short press
    clear_log();
    drive(1'b1, 10);
    drive(1'b0, 1);
    drive(1'b1, 2);
    drive(1'b0, 8);
    check("s6_long",   m_long,   64'h100);
    check("s6_held",   m_held,   64'h700);
    check("s6_short",  m_short,  64'h4_0000);
    check("s6_double", m_double, 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
